// File: rtl/bus_arbiter.sv
// bus_arbiter: merges the control, ADC and flash framed byte streams into one
// stream for the UART DMA transmit port. Arbitration is round-robin per frame,
// and a granted frame is never interleaved with another frame.
// Optional feature macro BUS_ARB_HEADER_EN: when defined, every frame is
// prefixed with its P_TYPE_* byte and o_tx_len counts that byte (saturating
// at 255). When it is undefined, the block is a pure frame-level multiplexer.
module bus_arbiter #(
  parameter logic [7:0] P_TYPE_CTRL  = 8'h01,
  parameter logic [7:0] P_TYPE_ADC   = 8'h02,
  parameter logic [7:0] P_TYPE_FLASH = 8'h03
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_ctrl_data,
  input  logic [7:0] i_ctrl_len,
  input  logic       i_ctrl_last,
  input  logic       i_ctrl_valid,
  output logic       o_ctrl_ready,
  input  logic [7:0] i_adc_data,
  input  logic [7:0] i_adc_len,
  input  logic       i_adc_last,
  input  logic       i_adc_valid,
  output logic       o_adc_ready,
  input  logic [7:0] i_flash_data,
  input  logic [7:0] i_flash_len,
  input  logic       i_flash_last,
  input  logic       i_flash_valid,
  output logic       o_flash_ready,
  output logic [7:0] o_tx_data,
  output logic [7:0] o_tx_len,
  output logic       o_tx_last,
  output logic       o_tx_valid,
  input  logic       i_tx_ready
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HEAD = 2'd1,
    S_DATA = 2'd2
  } state_t;

  localparam logic [1:0] SRC_CTRL  = 2'd0;
  localparam logic [1:0] SRC_ADC   = 2'd1;
  localparam logic [1:0] SRC_FLASH = 2'd2;

  state_t     state_q;
  logic [1:0] grant_q;     // source owning the current frame
  logic [1:0] last_src_q;  // last fully served source (round-robin pointer)
  logic [7:0] len_q;       // merged frame length shown on o_tx_len

  logic [2:0] req_s;
  logic [2:0] pick_s;      // {found, index} of the next source to grant
  logic [7:0] pick_len_s;
  logic [7:0] sel_data_s;
  logic       sel_last_s;
  logic       sel_valid_s;
  logic [7:0] type_s;
  logic       frame_end_s;

  // Successor of a source in the fixed ring ctrl -> adc -> flash -> ctrl.
  function automatic logic [1:0] rr_next(input logic [1:0] src);
    case (src)
      SRC_CTRL: rr_next = SRC_ADC;
      SRC_ADC:  rr_next = SRC_FLASH;
      default:  rr_next = SRC_CTRL;
    endcase
  endfunction

  // First requesting source after the last served one; MSB flags a hit.
  function automatic logic [2:0] rr_pick(input logic [1:0] last_src, input logic [2:0] req);
    logic [1:0] c0;
    logic [1:0] c1;
    logic [1:0] c2;
    c0 = rr_next(last_src);
    c1 = rr_next(c0);
    c2 = rr_next(c1);
    if (req[c0]) begin
      rr_pick = {1'b1, c0};
    end else if (req[c1]) begin
      rr_pick = {1'b1, c1};
    end else if (req[c2]) begin
      rr_pick = {1'b1, c2};
    end else begin
      rr_pick = {1'b0, SRC_CTRL};
    end
  endfunction

  // Length advertised for a frame, counting the type byte when it is sent.
  function automatic logic [7:0] frame_len(input logic [7:0] len);
`ifdef BUS_ARB_HEADER_EN
    if (len == 8'hFF) begin
      frame_len = 8'hFF;
    end else begin
      frame_len = len + 8'd1;
    end
`else
    frame_len = len;
`endif
  endfunction

  assign req_s       = {i_flash_valid, i_adc_valid, i_ctrl_valid};
  assign pick_s      = rr_pick(last_src_q, req_s);
  assign frame_end_s = sel_valid_s & sel_last_s & i_tx_ready;

  // Length of the source about to be granted, sampled in the IDLE cycle.
  always_comb begin
    case (pick_s[1:0])
      SRC_CTRL: pick_len_s = i_ctrl_len;
      SRC_ADC:  pick_len_s = i_adc_len;
      default:  pick_len_s = i_flash_len;
    endcase
  end

  // Stream and type byte of the currently granted source.
  always_comb begin
    case (grant_q)
      SRC_CTRL: begin
        sel_data_s  = i_ctrl_data;
        sel_last_s  = i_ctrl_last;
        sel_valid_s = i_ctrl_valid;
        type_s      = P_TYPE_CTRL;
      end
      SRC_ADC: begin
        sel_data_s  = i_adc_data;
        sel_last_s  = i_adc_last;
        sel_valid_s = i_adc_valid;
        type_s      = P_TYPE_ADC;
      end
      default: begin
        sel_data_s  = i_flash_data;
        sel_last_s  = i_flash_last;
        sel_valid_s = i_flash_valid;
        type_s      = P_TYPE_FLASH;
      end
    endcase
  end

  // Frame-level arbitration FSM: grant in IDLE, optional type byte, payload.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      grant_q    <= SRC_CTRL;
      last_src_q <= SRC_FLASH;
      len_q      <= 8'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pick_s[2]) begin
            grant_q <= pick_s[1:0];
            len_q   <= frame_len(pick_len_s);
`ifdef BUS_ARB_HEADER_EN
            state_q <= S_HEAD;
`else
            state_q <= S_DATA;
`endif
          end
        end
        S_HEAD: begin
          if (i_tx_ready) begin
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (frame_end_s) begin
            state_q    <= S_IDLE;
            last_src_q <= grant_q;
            len_q      <= 8'd0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          len_q   <= 8'd0;
        end
      endcase
    end
  end

  // Output mux: zeros in IDLE, type byte in HEAD, granted stream in DATA.
  always_comb begin
    o_tx_data     = 8'd0;
    o_tx_last     = 1'b0;
    o_tx_valid    = 1'b0;
    o_ctrl_ready  = 1'b0;
    o_adc_ready   = 1'b0;
    o_flash_ready = 1'b0;
    o_tx_len      = len_q;
    case (state_q)
      S_HEAD: begin
        o_tx_data  = type_s;
        o_tx_valid = 1'b1;
      end
      S_DATA: begin
        o_tx_data  = sel_data_s;
        o_tx_last  = sel_last_s;
        o_tx_valid = sel_valid_s;
        case (grant_q)
          SRC_CTRL: o_ctrl_ready  = i_tx_ready;
          SRC_ADC:  o_adc_ready   = i_tx_ready;
          default:  o_flash_ready = i_tx_ready;
        endcase
      end
      default: begin
        o_tx_data = 8'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed, table-driven bench for bus_arbiter plus short
// hand-written sequences for the multi-cycle corner cases. Expectations follow
// BUS_ARB_HEADER_EN the same way the design does.
module tb_bus_arbiter;

`ifdef BUS_ARB_HEADER_EN
  localparam bit HDR = 1'b1;
`else
  localparam bit HDR = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] c_data, a_data, f_data;
  logic [7:0] c_len, a_len, f_len;
  logic       c_last, a_last, f_last;
  logic       c_valid, a_valid, f_valid;
  logic       c_ready, a_ready, f_ready;
  logic [7:0] tx_data, tx_len;
  logic       tx_last, tx_valid, tx_ready;

  int checks;
  int failures;

  bus_arbiter dut (
    .i_clk(clk), .i_rst(rst),
    .i_ctrl_data(c_data), .i_ctrl_len(c_len), .i_ctrl_last(c_last),
    .i_ctrl_valid(c_valid), .o_ctrl_ready(c_ready),
    .i_adc_data(a_data), .i_adc_len(a_len), .i_adc_last(a_last),
    .i_adc_valid(a_valid), .o_adc_ready(a_ready),
    .i_flash_data(f_data), .i_flash_len(f_len), .i_flash_last(f_last),
    .i_flash_valid(f_valid), .o_flash_ready(f_ready),
    .o_tx_data(tx_data), .o_tx_len(tx_len), .o_tx_last(tx_last),
    .o_tx_valid(tx_valid), .i_tx_ready(tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [2:0] v;      // [0]=ctrl [1]=adc [2]=flash
    logic [7:0] cd, ad, fd;
    logic [2:0] l;
    logic [7:0] len;
    logic       txr;
    logic       e_valid;
    logic [7:0] e_data;
    logic       e_last;
    logic [7:0] e_len;
    logic [2:0] e_rdy;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic [2:0] v, input logic [7:0] cd, ad, fd,
                     input logic [2:0] l, input logic [7:0] len, input logic txr,
                     input logic ev, input logic [7:0] ed, input logic el,
                     input logic [7:0] elen, input logic [2:0] erdy);
    vec_t e;
    e.rst = r; e.v = v; e.cd = cd; e.ad = ad; e.fd = fd; e.l = l; e.len = len;
    e.txr = txr; e.e_valid = ev; e.e_data = ed; e.e_last = el; e.e_len = elen;
    e.e_rdy = erdy;
    tbl.push_back(e);
  endtask

  task automatic drv(input logic r, input logic [2:0] v, input logic [7:0] cd, ad, fd,
                     input logic [2:0] l, input logic [7:0] len, input logic txr);
    rst = r;
    c_valid = v[0]; a_valid = v[1]; f_valid = v[2];
    c_data = cd; a_data = ad; f_data = fd;
    c_last = l[0]; a_last = l[1]; f_last = l[2];
    c_len = len; a_len = len; f_len = len;
    tx_ready = txr;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    drv(1'b1, 3'b000, 8'd0, 8'd0, 8'd0, 3'b000, 8'd0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  function automatic logic [31:0] pack_out();
    return {11'd0, tx_valid, tx_last, f_ready, a_ready, c_ready, tx_data, tx_len};
  endfunction

  function automatic logic [31:0] pack_exp(input logic ev, input logic el, input logic [2:0] r,
                                           input logic [7:0] d, input logic [7:0] ln);
    return {11'd0, ev, el, r, d, ln};
  endfunction

  logic [7:0] la, l1;
  logic [7:0] cap_d[$];
  logic       cap_l[$];
  logic [7:0] fb[4];
  int idx, cyc, cnt_c, cnt_a;
  bit saw_last;

  initial begin
    checks = 0;
    failures = 0;
    drv(1'b1, 3'b000, 8'd0, 8'd0, 8'd0, 3'b000, 8'd0, 1'b0);
    la = HDR ? 8'd4 : 8'd3;
    l1 = HDR ? 8'd2 : 8'd1;

    // ADC frame 11,22,33 len=3 right after reset
    add(1'b1, 3'b000, 8'h00, 8'h00, 8'h00, 3'b000, 8'd0, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0, 3'b000);
    add(1'b0, 3'b010, 8'h00, 8'h11, 8'h00, 3'b000, 8'd3, 1'b1, 1'b0, 8'h00, 1'b0, 8'd0, 3'b000);
    if (HDR)
      add(1'b0, 3'b010, 8'h00, 8'h11, 8'h00, 3'b000, 8'd3, 1'b1, 1'b1, 8'h02, 1'b0, la, 3'b000);
    add(1'b0, 3'b010, 8'h00, 8'h11, 8'h00, 3'b000, 8'd3, 1'b1, 1'b1, 8'h11, 1'b0, la, 3'b010);
    add(1'b0, 3'b010, 8'h00, 8'h22, 8'h00, 3'b000, 8'd3, 1'b1, 1'b1, 8'h22, 1'b0, la, 3'b010);
    add(1'b0, 3'b010, 8'h00, 8'h33, 8'h00, 3'b010, 8'd3, 1'b1, 1'b1, 8'h33, 1'b1, la, 3'b010);
    add(1'b0, 3'b000, 8'h00, 8'h00, 8'h00, 3'b000, 8'd0, 1'b1, 1'b0, 8'h00, 1'b0, 8'd0, 3'b000);
    // reset, then all three sources request 1-byte frames together
    add(1'b1, 3'b000, 8'h00, 8'h00, 8'h00, 3'b000, 8'd0, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0, 3'b000);
    add(1'b0, 3'b111, 8'hC1, 8'hA1, 8'hF1, 3'b111, 8'd1, 1'b1, 1'b0, 8'h00, 1'b0, 8'd0, 3'b000);
    if (HDR)
      add(1'b0, 3'b111, 8'hC1, 8'hA1, 8'hF1, 3'b111, 8'd1, 1'b1, 1'b1, 8'h01, 1'b0, l1, 3'b000);
    add(1'b0, 3'b111, 8'hC1, 8'hA1, 8'hF1, 3'b111, 8'd1, 1'b1, 1'b1, 8'hC1, 1'b1, l1, 3'b001);
    add(1'b0, 3'b110, 8'h00, 8'hA1, 8'hF1, 3'b110, 8'd1, 1'b1, 1'b0, 8'h00, 1'b0, 8'd0, 3'b000);
    if (HDR)
      add(1'b0, 3'b110, 8'h00, 8'hA1, 8'hF1, 3'b110, 8'd1, 1'b1, 1'b1, 8'h02, 1'b0, l1, 3'b000);
    add(1'b0, 3'b110, 8'h00, 8'hA1, 8'hF1, 3'b110, 8'd1, 1'b1, 1'b1, 8'hA1, 1'b1, l1, 3'b010);
    add(1'b0, 3'b100, 8'h00, 8'h00, 8'hF1, 3'b100, 8'd1, 1'b1, 1'b0, 8'h00, 1'b0, 8'd0, 3'b000);
    if (HDR)
      add(1'b0, 3'b100, 8'h00, 8'h00, 8'hF1, 3'b100, 8'd1, 1'b1, 1'b1, 8'h03, 1'b0, l1, 3'b000);
    add(1'b0, 3'b100, 8'h00, 8'h00, 8'hF1, 3'b100, 8'd1, 1'b1, 1'b1, 8'hF1, 1'b1, l1, 3'b100);
    add(1'b0, 3'b000, 8'h00, 8'h00, 8'h00, 3'b000, 8'd0, 1'b1, 1'b0, 8'h00, 1'b0, 8'd0, 3'b000);

    @(posedge clk); #1;
    rst = 1'b1;
    foreach (tbl[i]) begin
      @(posedge clk); #1;
      drv(tbl[i].rst, tbl[i].v, tbl[i].cd, tbl[i].ad, tbl[i].fd, tbl[i].l, tbl[i].len, tbl[i].txr);
      @(negedge clk);
      chk($sformatf("row%0d", i), pack_out(),
          pack_exp(tbl[i].e_valid, tbl[i].e_last, tbl[i].e_rdy, tbl[i].e_data, tbl[i].e_len));
    end

    // flash 4-byte frame with i_tx_ready toggling 1,0,1,0; adc waits meanwhile
    do_reset();
    fb[0] = 8'hF0; fb[1] = 8'hF1; fb[2] = 8'hF2; fb[3] = 8'hF3;
    idx = 0; cyc = 0;
    while (idx < 4 && cyc < 40) begin
      @(posedge clk); #1;
      drv(1'b0, {1'b1, (cyc > 0), 1'b0}, 8'h00, 8'hAA, fb[idx], {(idx == 3), 1'b1, 1'b0},
          8'd4, (cyc % 2 == 0));
      a_len = 8'd1;
      @(negedge clk);
      chk("rr_others_ready", {30'd0, a_ready, c_ready}, 32'd0);
      if (tx_valid && tx_ready) begin
        cap_d.push_back(tx_data);
        cap_l.push_back(tx_last);
        chk("rr_len", {24'd0, tx_len}, HDR ? 32'd5 : 32'd4);
      end
      if (f_ready && f_valid) idx++;
      cyc++;
    end
    chk("rr_timeout", {31'd0, idx == 4}, 32'd1);
    chk("rr_count", cap_d.size(), HDR ? 32'd5 : 32'd4);
    for (int k = 0; k < cap_d.size() && k < 5; k++) begin
      chk($sformatf("rr_byte%0d", k), {24'd0, cap_d[k]},
          (HDR && k == 0) ? 32'h03 : {24'd0, fb[k - (HDR ? 1 : 0)]});
      chk($sformatf("rr_last%0d", k), {31'd0, cap_l[k]}, (k == cap_d.size() - 1) ? 32'd1 : 32'd0);
    end

    // ctrl requests continuously with adc pending: frames must alternate
    do_reset();
    cap_d.delete();
    cnt_c = 0; cnt_a = 0; cyc = 0;
    while (cap_d.size() < 3 && cyc < 40) begin
      @(posedge clk); #1;
      drv(1'b0, 3'b011, 8'hC0 + 8'(cnt_c), 8'hA0 + 8'(cnt_a), 8'h00, 3'b011, 8'd1, 1'b1);
      @(negedge clk);
      if (tx_valid && tx_last && tx_ready) cap_d.push_back(tx_data);
      if (c_ready) cnt_c++;
      if (a_ready) cnt_a++;
      cyc++;
    end
    chk("alt_count", cap_d.size(), 32'd3);
    if (cap_d.size() == 3) begin
      chk("alt_frame0", {24'd0, cap_d[0]}, 32'hC0);
      chk("alt_frame1", {24'd0, cap_d[1]}, 32'hA0);
      chk("alt_frame2", {24'd0, cap_d[2]}, 32'hC1);
    end

    // reset pulsed after 2 of 5 ctrl payload bytes
    do_reset();
    idx = 0; cyc = 0; saw_last = 1'b0;
    while (idx < 2 && cyc < 20) begin
      @(posedge clk); #1;
      drv(1'b0, 3'b001, 8'h51 + 8'(idx), 8'h00, 8'h00, {2'b00, (idx == 4)}, 8'd5, 1'b1);
      @(negedge clk);
      if (tx_last) saw_last = 1'b1;
      if (c_ready && c_valid) idx++;
      cyc++;
    end
    chk("rst_partial_timeout", {31'd0, idx == 2}, 32'd1);
    @(posedge clk); #1;
    drv(1'b1, 3'b000, 8'h00, 8'h00, 8'h00, 3'b000, 8'd0, 1'b1);
    @(posedge clk); #1;
    drv(1'b0, 3'b000, 8'h00, 8'h00, 8'h00, 3'b000, 8'd0, 1'b1);
    @(negedge clk);
    chk("rst_outputs_zero", pack_out(), 32'd0);
    chk("rst_no_last", {31'd0, saw_last}, 32'd0);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      drv(1'b0, 3'b001, 8'h61, 8'h00, 8'h00, 3'b001, 8'd1, 1'b1);
      @(negedge clk);
      cyc++;
    end while (!tx_valid && cyc < 10);
    chk("rst_restart_first", {23'd0, tx_valid, tx_data}, HDR ? 32'h101 : 32'h161);
    chk("rst_restart_len", {24'd0, tx_len}, HDR ? 32'd2 : 32'd1);

    // length saturation: ctrl len=255 then adc len=254
    do_reset();
    cyc = 0;
    do begin
      @(posedge clk); #1;
      drv(1'b0, 3'b001, 8'h77, 8'h00, 8'h00, 3'b001, 8'd255, 1'b1);
      @(negedge clk);
      cyc++;
    end while (!tx_valid && cyc < 10);
    chk("len255_first", {23'd0, tx_valid, tx_data}, HDR ? 32'h101 : 32'h177);
    chk("len255_len", {24'd0, tx_len}, 32'd255);
    cyc = 0;
    while (!c_ready && cyc < 10) begin
      @(posedge clk); #1;
      @(negedge clk);
      cyc++;
    end
    chk("len255_done", {31'd0, c_ready}, 32'd1);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      drv(1'b0, 3'b010, 8'h00, 8'h78, 8'h00, 3'b010, 8'd254, 1'b1);
      @(negedge clk);
      cyc++;
    end while (!tx_valid && cyc < 10);
    chk("len254_first", {23'd0, tx_valid, tx_data}, HDR ? 32'h102 : 32'h178);
    chk("len254_len", {24'd0, tx_len}, HDR ? 32'd255 : 32'd254);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
